// File: rtl/demux1x8_32bit_regbank_if.sv
// Write-port bundle for the 1-to-8 register bank.
// Valid/ready rule: a word moves on a rising clk edge where wr_valid and
// wr_ready are both high; the source holds D/S0..S2 stable until then.
interface demux1x8_32bit_regbank_if #(
    parameter int WIDTH = 32
);
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] D;
    logic             S0;
    logic             S1;
    logic             S2;

    // Write source: drives the request, observes ready
    modport master (
        output wr_valid,
        output D,
        output S0,
        output S1,
        output S2,
        input  wr_ready
    );

    // Register bank: consumes the request, drives ready
    modport slave (
        input  wr_valid,
        input  D,
        input  S0,
        input  S1,
        input  S2,
        output wr_ready
    );
endinterface

// File: rtl/demux1x8_32bit_regbank.sv
// 1-to-8 write demux into eight holding registers Q0..Q7, with per-register
// valid flags, an 8-cycle sequential clear sweep and a saturating count of
// accepted writes.
// Optional build macro: DEMUX_ZERO_LOCK_EN -- index 0 reads as hardwired zero
// (writes to it still handshake and are counted, but never store).
// dbg_state/dbg_idx expose the sweep FSM state and sweep index.
module demux1x8_32bit_regbank #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    demux1x8_32bit_regbank_if.slave   bus,
    input  logic                      clr_req,
    output logic                      busy,
    output logic [WIDTH-1:0]          Q0,
    output logic [WIDTH-1:0]          Q1,
    output logic [WIDTH-1:0]          Q2,
    output logic [WIDTH-1:0]          Q3,
    output logic [WIDTH-1:0]          Q4,
    output logic [WIDTH-1:0]          Q5,
    output logic [WIDTH-1:0]          Q6,
    output logic [WIDTH-1:0]          Q7,
    output logic [7:0]                vld,
    output logic [CNT_W-1:0]          wr_cnt,
    output logic                      dbg_state,
    output logic [2:0]                dbg_idx
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [2:0]       sweep_idx;
    logic [WIDTH-1:0] q_r [8];
    logic [2:0]       wr_idx;
    logic             accept;
    logic             store_en;

    // Ready depends only on FSM state and a pending clear, never on wr_valid,
    // so a clear request in the same cycle wins over a write.
    assign bus.wr_ready = (state == IDLE) & ~clr_req;
    assign wr_idx       = {bus.S2, bus.S1, bus.S0};
    assign accept       = bus.wr_valid & bus.wr_ready;

`ifdef DEMUX_ZERO_LOCK_EN
    // Index 0 is a zero register: the write completes but nothing is stored.
    assign store_en = accept & (wr_idx != 3'd0);
`else
    assign store_en = accept;
`endif

    // Sweep FSM: one register cleared per cycle, exits after index 7
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sweep_idx <= 3'd0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state     <= CLEAR;
                        sweep_idx <= 3'd0;
                        busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr_req is ignored here: the sweep is never restarted
                    sweep_idx <= sweep_idx + 3'd1;
                    if (sweep_idx == 3'd7) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    sweep_idx <= 3'd0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Holding registers and valid flags: sweep clears slot k, otherwise store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                q_r[i] <= '0;
            end
            vld <= 8'h00;
        end else if (state == CLEAR) begin
            q_r[sweep_idx] <= '0;
            vld[sweep_idx] <= 1'b0;
        end else if (store_en) begin
            q_r[wr_idx] <= bus.D;
            vld[wr_idx] <= 1'b1;
        end
    end

    // Accepted-write counter: saturates, only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
        end else if (accept && (wr_cnt != CNT_MAX)) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

    assign Q0 = q_r[0];
    assign Q1 = q_r[1];
    assign Q2 = q_r[2];
    assign Q3 = q_r[3];
    assign Q4 = q_r[4];
    assign Q5 = q_r[5];
    assign Q6 = q_r[6];
    assign Q7 = q_r[7];

    assign dbg_state = state;
    assign dbg_idx   = sweep_idx;

endmodule

// File: tb/tb_demux1x8_32bit_regbank.sv
// Self-checking bench for demux1x8_32bit_regbank. Accepted writes push the
// expected {index, value} onto exp_q; the entry is popped and compared once
// the registered output has updated.
module tb_demux1x8_32bit_regbank;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        busy;
    logic [31:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic [7:0]  vld;
    logic [7:0]  wr_cnt;
    logic        dbg_state;
    logic [2:0]  dbg_idx;

    demux1x8_32bit_regbank_if #(.WIDTH(32)) bus_if ();

    demux1x8_32bit_regbank #(.WIDTH(32), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .clr_req   (clr_req),
        .busy      (busy),
        .Q0        (Q0),
        .Q1        (Q1),
        .Q2        (Q2),
        .Q3        (Q3),
        .Q4        (Q4),
        .Q5        (Q5),
        .Q6        (Q6),
        .Q7        (Q7),
        .vld       (vld),
        .wr_cnt    (wr_cnt),
        .dbg_state (dbg_state),
        .dbg_idx   (dbg_idx)
    );

    wire [31:0] q_w [8];
    assign q_w[0] = Q0;
    assign q_w[1] = Q1;
    assign q_w[2] = Q2;
    assign q_w[3] = Q3;
    assign q_w[4] = Q4;
    assign q_w[5] = Q5;
    assign q_w[6] = Q6;
    assign q_w[7] = Q7;

    // scoreboard and reference model
    logic [34:0] exp_q[$];
    logic [31:0] m_q [8];
    logic [7:0]  m_vld;
    logic [7:0]  m_cnt;
    int          n_cmp;
    int          n_err;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear_bank();
        for (int i = 0; i < 8; i++) m_q[i] = 32'h0;
        m_vld = 8'h00;
    endtask

    task automatic set_sel(input logic [2:0] idx);
        bus_if.S0 = idx[0];
        bus_if.S1 = idx[1];
        bus_if.S2 = idx[2];
    endtask

    // Reset pulse; ends at a falling edge with reset released
    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear_bank();
        m_cnt = 8'h00;
        exp_q.delete();
    endtask

    // Reference update for one accepted write; pushes expected output
    task automatic model_write(input logic [2:0] idx, input logic [31:0] data);
`ifdef DEMUX_ZERO_LOCK_EN
        if (idx != 3'd0) begin
            m_q[idx]   = data;
            m_vld[idx] = 1'b1;
        end
`else
        m_q[idx]   = data;
        m_vld[idx] = 1'b1;
`endif
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        exp_q.push_back({idx, m_q[idx]});
    endtask

    // Driver: one write, waits (bounded) for acceptance; called at a falling edge
    task automatic do_write(input logic [2:0] idx, input logic [31:0] data);
        logic        ready_seen;
        bit          accepted;
        logic [34:0] e;
        accepted = 0;
        bus_if.wr_valid = 1'b1;
        set_sel(idx);
        bus_if.D = data;
        for (int c = 0; c < 40 && !accepted; c++) begin
            #1 ready_seen = bus_if.wr_ready;
            @(posedge clk);
            if (ready_seen === 1'b1) accepted = 1;
            @(negedge clk);
        end
        bus_if.wr_valid = 1'b0;
        n_cmp++;
        if (!accepted) begin
            n_err++;
            $display("FAIL write_accept idx=%0d: no acceptance within 40 cycles", idx);
        end else begin
            model_write(idx, data);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (q_w[e[34:32]] !== e[31:0]) begin
                n_err++;
                $display("FAIL write_q idx=%0d: got %h expected %h", e[34:32], q_w[e[34:32]], e[31:0]);
            end
        end
        n_cmp++;
        if (vld !== m_vld) begin
            n_err++;
            $display("FAIL write_vld: got %h expected %h", vld, m_vld);
        end
        n_cmp++;
        if (wr_cnt !== m_cnt) begin
            n_err++;
            $display("FAIL write_cnt: got %0d expected %0d", wr_cnt, m_cnt);
        end
    endtask

    task automatic test_reset();
        bit bad;
        do_write(3'd4, 32'hCAFE0004);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < 8; i++) if (q_w[i] !== 32'h0) bad = 1;
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL reset_q: Q4=%h expected all Q zero", Q4);
        end
        n_cmp++;
        if ({vld, wr_cnt, busy, dbg_state} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_state: vld=%h cnt=%0d busy=%b state=%b expected zeros", vld, wr_cnt, busy, dbg_state);
        end
        n_cmp++;
        if (bus_if.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b expected 1", bus_if.wr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear_bank();
        m_cnt = 8'h00;
        exp_q.delete();
    endtask

    task automatic test_single_write();
        bit bad;
        apply_reset();
        do_write(3'd5, 32'hDEADBEEF);
        bad = 0;
        for (int i = 0; i < 8; i++) if (i != 5 && q_w[i] !== 32'h0) bad = 1;
        n_cmp++;
        if (bad || vld !== 8'h20 || wr_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL single_write: Q5=%h vld=%h cnt=%0d others_nonzero=%b expected DEADBEEF 20 1 0",
                     Q5, vld, wr_cnt, bad);
        end
    endtask

    task automatic test_fill_and_clear();
        apply_reset();
        for (int i = 0; i < 8; i++) do_write(i[2:0], i + 1);
        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || bus_if.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_start: busy=%b ready=%b expected 1 0", busy, bus_if.wr_ready);
        end
        for (int j = 1; j <= 8; j++) begin
            if (j == 3) clr_req = 1'b1;   // must be ignored mid-sweep
            @(posedge clk);
            @(negedge clk);
            clr_req = 1'b0;
            m_q[j-1]   = 32'h0;
            m_vld[j-1] = 1'b0;
            n_cmp++;
            if (q_w[j-1] !== 32'h0 || vld !== m_vld) begin
                n_err++;
                $display("FAIL sweep_clear cycle %0d: Q%0d=%h vld=%h expected 0 %h", j, j-1, q_w[j-1], vld, m_vld);
            end
            if (j < 8) begin
                n_cmp++;
                if (q_w[j] !== m_q[j] || busy !== 1'b1 || bus_if.wr_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL sweep_hold cycle %0d: Q%0d=%h busy=%b ready=%b expected %h 1 0",
                             j, j, q_w[j], busy, bus_if.wr_ready, m_q[j]);
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || bus_if.wr_ready !== 1'b1 || vld !== 8'h00 || wr_cnt !== 8'd8) begin
            n_err++;
            $display("FAIL sweep_end: busy=%b ready=%b vld=%h cnt=%0d expected 0 1 00 8",
                     busy, bus_if.wr_ready, vld, wr_cnt);
        end
    endtask

    task automatic test_clr_priority();
        apply_reset();
        do_write(3'd3, 32'h0000AAAA);
        clr_req = 1'b1;
        bus_if.wr_valid = 1'b1;
        set_sel(3'd3);
        bus_if.D = 32'h00001234;
        #1;
        n_cmp++;
        if (bus_if.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL prio_ready: got %b expected 0", bus_if.wr_ready);
        end
        @(posedge clk);
        @(negedge clk);
        clr_req = 1'b0;
        bus_if.wr_valid = 1'b0;
        n_cmp++;
        if (Q3 !== 32'h0000AAAA || busy !== 1'b1 || wr_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL prio_reject: Q3=%h busy=%b cnt=%0d expected 0000aaaa 1 1", Q3, busy, wr_cnt);
        end
        repeat (8) @(negedge clk);
        model_clear_bank();
        n_cmp++;
        if (busy !== 1'b0 || Q3 !== 32'h0 || vld !== 8'h00) begin
            n_err++;
            $display("FAIL prio_sweep_done: busy=%b Q3=%h vld=%h expected 0 0 00", busy, Q3, vld);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit bad;
        apply_reset();
        do_write(3'd6, 32'h66666666);
        do_write(3'd1, 32'h11111111);
        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (Q1 !== 32'h0 || Q6 !== 32'h66666666 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL midsweep_progress: Q1=%h Q6=%h busy=%b expected 0 66666666 1", Q1, Q6, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < 8; i++) if (q_w[i] !== 32'h0) bad = 1;
        n_cmp++;
        if (bad || vld !== 8'h00 || wr_cnt !== 8'd0 || busy !== 1'b0 || dbg_state !== 1'b0) begin
            n_err++;
            $display("FAIL midsweep_reset: Q6=%h vld=%h cnt=%0d busy=%b state=%b expected all zero",
                     Q6, vld, wr_cnt, busy, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear_bank();
        m_cnt = 8'h00;
        exp_q.delete();
        do_write(3'd2, 32'h22222222);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  tbl [6];
        logic [31:0] data;
        logic [34:0] e;
        apply_reset();
        tbl[0] = 3'd2; tbl[1] = 3'd2; tbl[2] = 3'd7;
        tbl[3] = 3'd2; tbl[4] = 3'd0; tbl[5] = 3'd7;
        bus_if.wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data = $urandom;
            set_sel(tbl[i]);
            bus_if.D = data;
            #1;
            n_cmp++;
            if (bus_if.wr_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready %0d: got %b expected 1", i, bus_if.wr_ready);
            end
            @(posedge clk);
            model_write(tbl[i], data);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (q_w[e[34:32]] !== e[31:0]) begin
                n_err++;
                $display("FAIL b2b_q %0d idx=%0d: got %h expected %h", i, e[34:32], q_w[e[34:32]], e[31:0]);
            end
        end
        bus_if.wr_valid = 1'b0;
        n_cmp++;
        if (Q2 !== m_q[2] || vld !== m_vld || wr_cnt !== 8'd6) begin
            n_err++;
            $display("FAIL b2b_final: Q2=%h vld=%h cnt=%0d expected %h %h 6", Q2, vld, wr_cnt, m_q[2], m_vld);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            do_write(3'($urandom_range(0, 7)), $urandom);
        end
        n_cmp++;
        if (wr_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL saturation: got %0d expected 255", wr_cnt);
        end
    endtask

    task automatic test_zero_index();
        apply_reset();
        do_write(3'd0, 32'hFFFFFFFF);
        n_cmp++;
`ifdef DEMUX_ZERO_LOCK_EN
        if (Q0 !== 32'h0 || vld[0] !== 1'b0 || wr_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL zero_index: Q0=%h vld0=%b cnt=%0d expected 0 0 1", Q0, vld[0], wr_cnt);
        end
`else
        if (Q0 !== 32'hFFFFFFFF || vld[0] !== 1'b1 || wr_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL zero_index: Q0=%h vld0=%b cnt=%0d expected ffffffff 1 1", Q0, vld[0], wr_cnt);
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clr_req = 1'b0;
        bus_if.wr_valid = 1'b0;
        bus_if.D = 32'h0;
        set_sel(3'd0);
        model_clear_bank();
        m_cnt = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_single_write();
        test_fill_and_clear();
        test_clr_priority();
        test_reset_mid_sweep();
        test_back_to_back();
        test_saturation();
        test_zero_index();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
